// File: rtl/norm_pkg.sv
// Shared types and sizing for the pixel normalizer.
// Optional NORM_ROUND_EN selects round-half-up scaling instead of truncation.
package norm_pkg;

    localparam int PIXEL_BIT_WIDTH = 10;
    localparam int OUT_BIT_WIDTH   = 8;
    localparam int FRAC_BITS       = 16;
    localparam int OUT_ROWS        = 10;
    localparam int OUT_COLS        = 10;

    localparam int DIV_W  = OUT_BIT_WIDTH + FRAC_BITS;
    localparam int NPIX   = OUT_ROWS * OUT_COLS;
    localparam int PROD_W = PIXEL_BIT_WIDTH + DIV_W;

    typedef enum logic [1:0] {
        IDLE,
        RECIP,
        STREAM
    } state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pixel_normalizer_if.sv
// Control and AXI-stream bundle of the pixel normalizer.
// The design side uses slave, the driving side uses master.
interface pixel_normalizer_if;
    import norm_pkg::*;

    logic                       ap_start;
    logic                       ap_ready;
    logic                       ap_done;
    logic [PIXEL_BIT_WIDTH-1:0] max_value;

    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata;

    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [OUT_BIT_WIDTH-1:0]   m_axis_tdata;
    logic                       m_axis_tlast;

    modport slave (
        input  ap_start, max_value,
        input  s_axis_tvalid, s_axis_tdata,
        input  m_axis_tready,
        output ap_ready, ap_done,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata,
        output m_axis_tlast
    );

    modport master (
        output ap_start, max_value,
        output s_axis_tvalid, s_axis_tdata,
        output m_axis_tready,
        input  ap_ready, ap_done,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata,
        input  m_axis_tlast
    );

endinterface

// File: rtl/recip_divider.sv
// Serial restoring divider: quotient = ((2^OUT-1) << FRAC) / divisor,
// one quotient bit per cycle; a zero divisor finishes at once with 0.
module recip_divider
    import norm_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [PIXEL_BIT_WIDTH-1:0] divisor,
    output logic                       busy,
    output logic                       done,
    output logic [DIV_W-1:0]           quotient
);

    localparam int CW = $clog2(DIV_W);
    localparam logic [DIV_W-1:0] DIVIDEND =
        {{OUT_BIT_WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};

    logic                       zero;
    logic [CW-1:0]              cnt;
    logic [PIXEL_BIT_WIDTH-1:0] dsr;
    logic [PIXEL_BIT_WIDTH-1:0] rem;
    logic [DIV_W-1:0]           dvd;
    logic [PIXEL_BIT_WIDTH:0]   trial;
    logic [PIXEL_BIT_WIDTH:0]   diff;
    logic                       ge;

    // Remainder stays below the divisor, so the trial is below twice it
    // and the difference MSB is a clean borrow flag.
    always_comb begin
        trial = {rem, dvd[DIV_W-1]};
        diff  = trial - {1'b0, dsr};
        ge    = !diff[PIXEL_BIT_WIDTH];
    end

    assign done = busy && (zero || cnt == CW'(DIV_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            zero     <= 1'b0;
            cnt      <= '0;
            dsr      <= '0;
            rem      <= '0;
            dvd      <= '0;
            quotient <= '0;
        end else if (start && !busy) begin
            busy     <= 1'b1;
            zero     <= (divisor == '0);
            cnt      <= '0;
            dsr      <= divisor;
            rem      <= '0;
            dvd      <= DIVIDEND;
            quotient <= '0;
        end else if (busy) begin
            if (zero) begin
                busy <= 1'b0;
            end else begin
                rem      <= ge ? diff[PIXEL_BIT_WIDTH-1:0]
                               : trial[PIXEL_BIT_WIDTH-1:0];
                quotient <= {quotient[DIV_W-2:0], ge};
                dvd      <= dvd << 1;
                cnt      <= cnt + 1'b1;
                if (cnt == CW'(DIV_W - 1))
                    busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pixel_normalizer.sv
// Scales each cropped pixel to full output range via a per-frame reciprocal.
// Define NORM_ROUND_EN for round-half-up; default build truncates.
module pixel_normalizer
    import norm_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    pixel_normalizer_if.slave bus
);

    localparam int CW = cnt_w(NPIX);
    localparam logic [OUT_BIT_WIDTH-1:0] OMAX = '1;
`ifdef NORM_ROUND_EN
    localparam logic [PROD_W:0] RND = (PROD_W + 1)'(2 ** (FRAC_BITS - 1));
`else
    localparam logic [PROD_W:0] RND = '0;
`endif

    state_t                   state;
    logic [CW-1:0]            in_cnt;
    logic [CW-1:0]            out_cnt;
    logic                     s1_v;
    logic [PROD_W-1:0]        s1_prod;
    logic                     m_v;
    logic [OUT_BIT_WIDTH-1:0] m_data;

    logic                     div_start;
    logic                     div_busy;
    logic                     div_done;
    logic [DIV_W-1:0]         recip;

    logic                     out_rdy;
    logic                     s_rdy;
    logic                     in_acc;
    logic                     out_acc;
    logic                     last_acc;
    logic [PROD_W:0]          sum;
    logic [PROD_W:0]          shf;
    logic [OUT_BIT_WIDTH-1:0] res;

    assign div_start = (state == IDLE) && bus.ap_start && !div_busy;
    assign out_rdy   = !m_v || bus.m_axis_tready;
    assign s_rdy     = (state == STREAM) && (!s1_v || out_rdy)
                       && (in_cnt < CW'(NPIX));
    assign in_acc    = s_rdy && bus.s_axis_tvalid;
    assign out_acc   = m_v && bus.m_axis_tready;
    assign last_acc  = (state == STREAM) && out_acc
                       && (out_cnt == CW'(NPIX - 1));

    always_comb begin
        sum = {1'b0, s1_prod} + RND;
        shf = sum >> FRAC_BITS;
        res = (shf > (PROD_W + 1)'(OMAX)) ? OMAX : shf[OUT_BIT_WIDTH-1:0];
    end

    recip_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .divisor  (bus.max_value),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (recip)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            s1_v    <= 1'b0;
            s1_prod <= '0;
            m_v     <= 1'b0;
            m_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.ap_start) begin
                        state   <= RECIP;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                RECIP:   if (div_done) state <= STREAM;
                STREAM:  if (last_acc) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (in_acc)
                in_cnt <= in_cnt + 1'b1;
            if (out_acc)
                out_cnt <= out_cnt + 1'b1;

            if (in_acc) begin
                s1_v    <= 1'b1;
                s1_prod <= PROD_W'(bus.s_axis_tdata) * PROD_W'(recip);
            end else if (out_rdy) begin
                s1_v <= 1'b0;
            end

            if (out_rdy) begin
                m_v <= s1_v;
                if (s1_v)
                    m_data <= res;
            end
        end
    end

    assign bus.ap_ready      = (state == IDLE);
    assign bus.ap_done       = last_acc;
    assign bus.s_axis_tready = s_rdy;
    assign bus.m_axis_tvalid = m_v;
    assign bus.m_axis_tdata  = m_data;
    assign bus.m_axis_tlast  = (out_cnt == CW'(NPIX - 1));

endmodule

// File: tb/tb_pixel_normalizer.sv
// Directed bench for pixel_normalizer: frame vectors, stalls, mid-frame reset.
// Honours NORM_ROUND_EN for the expected rounding mode.
module tb_pixel_normalizer;
    import norm_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pixel_normalizer_if bus ();

    pixel_normalizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int mx;
        int px;
        int exp_t;
        int exp_r;
        int rcyc;
        bit poke;
    } vec_t;

    vec_t vecs[5];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model(input int px, input int mx);
        longint rc;
        longint p;
        rc = (mx == 0) ? 0 : ((longint'(255) << 16) / mx);
        p  = longint'(px) * rc;
`ifdef NORM_ROUND_EN
        p  = p + 32768;
`endif
        p  = p >> 16;
        return (p > 255) ? 255 : int'(p);
    endfunction

    task automatic run_frame(input int mx, input bit ramp, input int pval,
                             input int expv, input bit stall,
                             input int rcyc, input bit poke);
        int  rc;
        int  nin;
        int  nout;
        int  want;
        bit  hold;
        bit  done;
        bit  ev;
        logic [7:0] hdata;
        logic       hlast;

        bus.ap_start  = 1'b1;
        bus.max_value = 10'(mx);
        @(posedge clk); #1;
        bus.ap_start = 1'b0;
        chk("ap_ready_low", bus.ap_ready, 0);

        rc = 0;
        while (!bus.s_axis_tready && rc < 200) begin
            rc++;
            @(posedge clk); #1;
        end
        chk("recip_cycles", rc, rcyc);

        nin   = 0;
        nout  = 0;
        hold  = 0;
        done  = 0;
        hdata = '0;
        hlast = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (poke) begin
                bus.ap_start  = 1'b1;
                bus.max_value = 10'd1;
            end
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = ramp ? 10'(nin * 10) : 10'(pval);
            bus.m_axis_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (hold) begin
                chk("stall_valid", bus.m_axis_tvalid, 1);
                chk("stall_data", bus.m_axis_tdata, hdata);
                chk("stall_last", bus.m_axis_tlast, hlast);
            end
            if (nin >= NPIX)
                chk("s_tready_after_last", bus.s_axis_tready, 0);
            ev = bus.m_axis_tvalid && bus.m_axis_tready && (nout == NPIX - 1);
            chk("ap_done", bus.ap_done, ev);
            if (bus.s_axis_tvalid && bus.s_axis_tready)
                nin++;
            if (bus.m_axis_tvalid) begin
                hold  = !bus.m_axis_tready;
                hdata = bus.m_axis_tdata;
                hlast = bus.m_axis_tlast;
                if (bus.m_axis_tready) begin
                    want = ramp ? model(nout * 10, mx) : expv;
                    chk("out_data", bus.m_axis_tdata, want);
                    chk("out_last", bus.m_axis_tlast, nout == NPIX - 1);
                    nout++;
                end
            end else begin
                hold = 0;
            end
            if (bus.ap_done)
                done = 1;
            @(posedge clk); #1;
        end
        chk("done_seen", done, 1);
        chk("out_count", nout, NPIX);
        chk("in_count", nin, NPIX);

        bus.ap_start      = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b0;
        @(negedge clk);
        chk("ap_ready_after", bus.ap_ready, 1);
        chk("m_tvalid_after", bus.m_axis_tvalid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        if (poke)
            chk("start_on_done_ignored", bus.ap_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{mx: 1023, px: 1023, exp_t: 254, exp_r: 255, rcyc: 24, poke: 1};
        vecs[1] = '{mx: 100,  px: 50,   exp_t: 127, exp_r: 127, rcyc: 24, poke: 0};
        vecs[2] = '{mx: 100,  px: 100,  exp_t: 254, exp_r: 255, rcyc: 24, poke: 0};
        vecs[3] = '{mx: 0,    px: 777,  exp_t: 0,   exp_r: 0,   rcyc: 1,  poke: 0};
        vecs[4] = '{mx: 100,  px: 200,  exp_t: 255, exp_r: 255, rcyc: 24, poke: 0};

        reset             = 1'b1;
        bus.ap_start      = 1'b0;
        bus.max_value     = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ap_ready", bus.ap_ready, 1);
        chk("rst_ap_done", bus.ap_done, 0);
        chk("rst_s_tready", bus.s_axis_tready, 0);
        chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_m_tdata", bus.m_axis_tdata, 0);
        chk("rst_m_tlast", bus.m_axis_tlast, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
`ifdef NORM_ROUND_EN
            run_frame(vecs[i].mx, 0, vecs[i].px, vecs[i].exp_r, 0,
                      vecs[i].rcyc, vecs[i].poke);
`else
            run_frame(vecs[i].mx, 0, vecs[i].px, vecs[i].exp_t, 0,
                      vecs[i].rcyc, vecs[i].poke);
`endif
        end

        run_frame(1000, 1, 0, 0, 1, 24, 0);

        bus.ap_start  = 1'b1;
        bus.max_value = 10'd100;
        @(posedge clk); #1;
        bus.ap_start      = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 10'd50;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mid_stream_valid", bus.m_axis_tvalid, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("mid_rst_ap_ready", bus.ap_ready, 1);
        @(posedge clk); #1;
        reset             = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b0;
        @(posedge clk); #1;

        run_frame(1000, 1, 0, 0, 0, 24, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
